// File: rtl/muldiv_if.sv
// Pipeline-side handshake and result bus for the iterative multiply/divide controller.
// The EX stage drives requests as master; the controller answers as slave.
interface muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             rd_req;
    logic             flush;
    logic             busy;
    logic             done;
    logic             stall;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, rd_req, flush,
        input  busy, done, stall, hi, lo
    );

    modport slave (
        input  start, op, a, b, rd_req, flush,
        output busy, done, stall, hi, lo
    );
endinterface

// File: rtl/muldiv_controller.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer with HI/LO ownership and pipeline stall request.
// state | meaning
// IDLE  | waiting for an op; MTHI/MTLO complete here in one cycle
// CALC  | one shift-add or restoring-subtract step per cycle, WIDTH steps
// FIX   | apply result signs, write HI/LO, pulse done next cycle
module muldiv_controller #(
    parameter int WIDTH = 32
) (
    input logic     clk,
    input logic     rst_n,
    muldiv_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH-1:0] opnd;
    logic [WIDTH-1:0] a_raw;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             is_div;
    logic             neg_lo;
    logic             neg_hi;
    logic             div_zero;
    logic             done_q;

    logic             accept;
    logic             iter_op;
    logic             signed_op;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH+1:0]   div_diff;
    logic               div_ok;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   fix_hi;
    logic [WIDTH-1:0]   fix_lo;

    assign accept    = (state == IDLE) && bus.start && !bus.flush;
    assign iter_op   = !bus.op[2];
    assign signed_op = !bus.op[0];
    assign a_neg     = signed_op && bus.a[WIDTH-1];
    assign b_neg     = signed_op && bus.b[WIDTH-1];
    assign a_mag     = a_neg ? -bus.a : bus.a;
    assign b_mag     = b_neg ? -bus.b : bus.b;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept && iter_op) begin
                    state_nxt = CALC;
                end
            end
            CALC: begin
                if (bus.flush) begin
                    state_nxt = IDLE;
                end else if (count == CW'(WIDTH - 1)) begin
                    state_nxt = FIX;
                end
            end
            FIX: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Multiply keeps the multiplier in acc_lo and shifts the running sum in from the top;
    // divide keeps the dividend in acc_lo and shifts quotient bits in from the bottom.
    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : {(WIDTH + 1){1'b0}});
        div_shift = {acc_hi, acc_lo[WIDTH-1]};
        div_diff  = {1'b0, div_shift} - {2'b00, opnd};
        div_ok    = !div_diff[WIDTH+1];
    end

    always_comb begin
        prod     = {acc_hi, acc_lo};
        prod_fix = neg_lo ? -prod : prod;
        quo_fix  = neg_lo ? -acc_lo : acc_lo;
        rem_fix  = neg_hi ? -acc_hi : acc_hi;
        if (div_zero) begin
            fix_hi = a_raw;
            fix_lo = {WIDTH{1'b1}};
        end else if (is_div) begin
            fix_hi = rem_fix;
            fix_lo = quo_fix;
        end else begin
            fix_hi = prod_fix[2*WIDTH-1:WIDTH];
            fix_lo = prod_fix[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count    <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            opnd     <= '0;
            a_raw    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            is_div   <= 1'b0;
            neg_lo   <= 1'b0;
            neg_hi   <= 1'b0;
            div_zero <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        case (bus.op)
                            OP_MULT, OP_MULTU: begin
                                opnd     <= a_mag;
                                acc_lo   <= b_mag;
                                acc_hi   <= '0;
                                is_div   <= 1'b0;
                                neg_lo   <= a_neg ^ b_neg;
                                neg_hi   <= 1'b0;
                                div_zero <= 1'b0;
                                count    <= '0;
                            end
                            OP_DIV, OP_DIVU: begin
                                opnd     <= b_mag;
                                acc_lo   <= a_mag;
                                acc_hi   <= '0;
                                a_raw    <= bus.a;
                                is_div   <= 1'b1;
                                neg_lo   <= a_neg ^ b_neg;
                                neg_hi   <= a_neg;
                                div_zero <= (bus.b == '0);
                                count    <= '0;
                            end
                            OP_MTHI: hi_q <= bus.a;
                            OP_MTLO: lo_q <= bus.a;
                            default: ;
                        endcase
                    end
                end
                CALC: begin
                    if (!bus.flush) begin
                        count <= count + 1'b1;
                        if (is_div) begin
                            acc_hi <= div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
                            acc_lo <= {acc_lo[WIDTH-2:0], div_ok};
                        end else begin
                            {acc_hi, acc_lo} <= {mul_sum, acc_lo[WIDTH-1:1]};
                        end
                    end
                end
                FIX: begin
                    if (!bus.flush) begin
                        hi_q   <= fix_hi;
                        lo_q   <= fix_lo;
                        done_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy  = (state != IDLE);
    assign bus.stall = (state != IDLE) && (bus.start || bus.rd_req);
    assign bus.done  = done_q;
    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;
endmodule

// File: tb/tb_muldiv_controller.sv
// Self-checking bench for muldiv_controller: directed corner cases plus randomized ops
// compared against a plain-arithmetic model of MULT/MULTU/DIV/DIVU.
module tb_muldiv_controller;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    muldiv_if #(.WIDTH(32)) bus ();

    muldiv_controller #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic logic [63:0] ref_result(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] sx64;
        logic [63:0] sy64;
        int          sx;
        int          sy;
        sx64 = {{32{x[31]}}, x};
        sy64 = {{32{y[31]}}, y};
        sx   = $signed(x);
        sy   = $signed(y);
        case (o)
            3'b000: return sx64 * sy64;
            3'b001: return {32'h0, x} * {32'h0, y};
            3'b010: begin
                if (y == 32'h0) return {x, 32'hFFFFFFFF};
                if (x == 32'h80000000 && y == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
                return {32'(sx % sy), 32'(sx / sy)};
            end
            3'b011: begin
                if (y == 32'h0) return {x, 32'hFFFFFFFF};
                return {x % y, x / y};
            end
            default: return 64'h0;
        endcase
    endfunction

    // Issues one op from the current (post-edge) time and follows it until busy drops.
    task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                          output int bcyc, output int dcyc);
        bus.start = 1'b1;
        bus.op    = o;
        bus.a     = x;
        bus.b     = y;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bcyc = 0;
        dcyc = 0;
        while (bus.busy === 1'b1 && bcyc < 100) begin
            bcyc++;
            if (bus.done === 1'b1) dcyc++;
            @(posedge clk);
            #1;
        end
        if (bus.done === 1'b1) dcyc++;
        @(posedge clk);
        #1;
        if (bus.done === 1'b1) dcyc++;
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        bus.start  = 1'b0;
        bus.op     = 3'b110;
        bus.a      = '0;
        bus.b      = '0;
        bus.rd_req = 1'b0;
        bus.flush  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", bus.done); end
        checks++; if (bus.hi !== 32'h0) begin failures++; $display("FAIL reset_hi got=%h exp=0", bus.hi); end
        checks++; if (bus.lo !== 32'h0) begin failures++; $display("FAIL reset_lo got=%h exp=0", bus.lo); end
        bus.rd_req = 1'b1;
        #1;
        checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL idle_stall got=%b exp=0", bus.stall); end
        bus.rd_req = 1'b0;
    endtask

    task automatic test_multu_max();
        int bc, dc;
        run_op(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, bc, dc);
        checks++; if (bc !== 33) begin failures++; $display("FAIL multu_busy_cycles got=%0d exp=33", bc); end
        checks++; if (dc !== 1) begin failures++; $display("FAIL multu_done_pulses got=%0d exp=1", dc); end
        checks++; if (bus.hi !== 32'hFFFFFFFE) begin failures++; $display("FAIL multu_hi got=%h exp=fffffffe", bus.hi); end
        checks++; if (bus.lo !== 32'h00000001) begin failures++; $display("FAIL multu_lo got=%h exp=00000001", bus.lo); end
    endtask

    task automatic test_directed();
        logic [2:0]  ops [4];
        logic [31:0] xs  [4];
        logic [31:0] ys  [4];
        logic [31:0] ehi [4];
        logic [31:0] elo [4];
        int bc, dc;
        ops[0] = 3'b000; xs[0] = 32'hFFFFFFFD; ys[0] = 32'd5;        ehi[0] = 32'hFFFFFFFF; elo[0] = 32'hFFFFFFF1;
        ops[1] = 3'b010; xs[1] = 32'hFFFFFFF9; ys[1] = 32'd2;        ehi[1] = 32'hFFFFFFFF; elo[1] = 32'hFFFFFFFD;
        ops[2] = 3'b011; xs[2] = 32'd10;       ys[2] = 32'd0;        ehi[2] = 32'h0000000A; elo[2] = 32'hFFFFFFFF;
        ops[3] = 3'b010; xs[3] = 32'h80000000; ys[3] = 32'hFFFFFFFF; ehi[3] = 32'h00000000; elo[3] = 32'h80000000;
        for (int i = 0; i < 4; i++) begin
            run_op(ops[i], xs[i], ys[i], bc, dc);
            checks++; if (bus.hi !== ehi[i]) begin failures++; $display("FAIL directed%0d_hi got=%h exp=%h", i, bus.hi, ehi[i]); end
            checks++; if (bus.lo !== elo[i]) begin failures++; $display("FAIL directed%0d_lo got=%h exp=%h", i, bus.lo, elo[i]); end
            checks++; if (bc !== 33 || dc !== 1) begin failures++; $display("FAIL directed%0d_timing got busy=%0d done=%0d exp 33/1", i, bc, dc); end
        end
    endtask

    task automatic test_mthi_mtlo();
        logic [31:0] lo0;
        lo0 = bus.lo;
        bus.start = 1'b1; bus.op = 3'b100; bus.a = 32'h12345678;
        @(posedge clk); #1;
        checks++; if (bus.hi !== 32'h12345678) begin failures++; $display("FAIL mthi_hi got=%h exp=12345678", bus.hi); end
        checks++; if (bus.lo !== lo0) begin failures++; $display("FAIL mthi_lo_hold got=%h exp=%h", bus.lo, lo0); end
        checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin failures++; $display("FAIL mthi_flags got busy=%b done=%b exp 0/0", bus.busy, bus.done); end
        bus.op = 3'b101; bus.a = 32'h9ABCDEF0;
        @(posedge clk); #1;
        checks++; if (bus.lo !== 32'h9ABCDEF0) begin failures++; $display("FAIL mtlo_lo got=%h exp=9abcdef0", bus.lo); end
        checks++; if (bus.hi !== 32'h12345678) begin failures++; $display("FAIL mtlo_hi_hold got=%h exp=12345678", bus.hi); end
        checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin failures++; $display("FAIL mtlo_flags got busy=%b done=%b exp 0/0", bus.busy, bus.done); end
        bus.op = 3'b100; bus.a = 32'hDEADBEEF; bus.flush = 1'b1;
        @(posedge clk); #1;
        checks++; if (bus.hi !== 32'h12345678) begin failures++; $display("FAIL idle_flush_wins got=%h exp=12345678", bus.hi); end
        bus.flush = 1'b0; bus.op = 3'b110; bus.a = 32'h55555555;
        @(posedge clk); #1;
        checks++; if (bus.hi !== 32'h12345678 || bus.lo !== 32'h9ABCDEF0 || bus.busy !== 1'b0)
            begin failures++; $display("FAIL noop_effect got hi=%h lo=%h busy=%b", bus.hi, bus.lo, bus.busy); end
        bus.start = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        checks++; if (bus.hi !== 32'h0 || bus.lo !== 32'h0) begin failures++; $display("FAIL reset_clears got hi=%h lo=%h exp 0/0", bus.hi, bus.lo); end
    endtask

    task automatic test_stall();
        logic [31:0] x, y, oldhi, oldlo;
        logic [63:0] exp;
        logic        exp_stall;
        bus.start = 1'b1; bus.op = 3'b100; bus.a = 32'h11111111;
        @(posedge clk); #1;
        bus.op = 3'b101; bus.a = 32'h22222222;
        @(posedge clk); #1;
        oldhi = bus.hi; oldlo = bus.lo;
        x = $urandom; y = $urandom;
        exp = ref_result(3'b000, x, y);
        bus.op = 3'b000; bus.a = x; bus.b = y;
        @(posedge clk); #1;
        for (int k = 0; k <= 35; k++) begin
            bus.rd_req = (k == 5);
            bus.start  = (k == 10);
            if (k == 10) begin bus.op = 3'b011; bus.a = $urandom; bus.b = $urandom_range(1, 100); end
            #1;
            exp_stall = (k == 5 || k == 10);
            checks++; if (bus.stall !== exp_stall) begin failures++; $display("FAIL stall_k%0d got=%b exp=%b", k, bus.stall, exp_stall); end
            checks++; if (bus.busy !== (k <= 32)) begin failures++; $display("FAIL stall_busy_k%0d got=%b exp=%b", k, bus.busy, (k <= 32)); end
            checks++; if (bus.done !== (k == 33)) begin failures++; $display("FAIL stall_done_k%0d got=%b exp=%b", k, bus.done, (k == 33)); end
            if (k < 33) begin
                checks++; if (bus.hi !== oldhi || bus.lo !== oldlo) begin failures++; $display("FAIL stall_hold_k%0d got=%h_%h exp=%h_%h", k, bus.hi, bus.lo, oldhi, oldlo); end
            end else begin
                checks++; if ({bus.hi, bus.lo} !== exp) begin failures++; $display("FAIL stall_result_k%0d got=%h_%h exp=%h", k, bus.hi, bus.lo, exp); end
            end
            @(posedge clk); #1;
        end
        bus.rd_req = 1'b0; bus.start = 1'b0;
    endtask

    task automatic test_flush();
        logic [31:0] oldhi, oldlo, x, y;
        logic [63:0] exp;
        int bc, dc;
        oldhi = bus.hi; oldlo = bus.lo;
        bus.start = 1'b1; bus.op = 3'b000; bus.a = $urandom; bus.b = $urandom;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int k = 0; k <= 11; k++) begin
            bus.flush = (k == 10);
            checks++; if (bus.busy !== (k <= 10)) begin failures++; $display("FAIL flush_busy_k%0d got=%b exp=%b", k, bus.busy, (k <= 10)); end
            checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL flush_done_k%0d got=%b exp=0", k, bus.done); end
            checks++; if (bus.hi !== oldhi || bus.lo !== oldlo) begin failures++; $display("FAIL flush_hold_k%0d got=%h_%h exp=%h_%h", k, bus.hi, bus.lo, oldhi, oldlo); end
            if (k < 11) begin @(posedge clk); #1; end
        end
        bus.flush = 1'b0;
        x = $urandom; y = $urandom_range(1, 1000);
        exp = ref_result(3'b011, x, y);
        run_op(3'b011, x, y, bc, dc);
        checks++; if (bc !== 33 || dc !== 1) begin failures++; $display("FAIL post_flush_timing got busy=%0d done=%0d exp 33/1", bc, dc); end
        checks++; if ({bus.hi, bus.lo} !== exp) begin failures++; $display("FAIL post_flush_result got=%h_%h exp=%h", bus.hi, bus.lo, exp); end
    endtask

    task automatic test_reset_mid();
        int dcnt, bcnt;
        bus.start = 1'b1; bus.op = 3'b001; bus.a = 32'hFFFFFFFF; bus.b = 32'h3;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        checks++; if (bus.busy !== 1'b0 || bus.hi !== 32'h0 || bus.lo !== 32'h0)
            begin failures++; $display("FAIL reset_mid got busy=%b hi=%h lo=%h exp 0/0/0", bus.busy, bus.hi, bus.lo); end
        dcnt = 0; bcnt = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) dcnt++;
            if (bus.busy === 1'b1) bcnt++;
        end
        checks++; if (dcnt !== 0 || bcnt !== 0) begin failures++; $display("FAIL reset_mid_discard got done=%0d busy=%0d exp 0/0", dcnt, bcnt); end
    endtask

    task automatic test_random();
        logic [2:0]  o;
        logic [31:0] x, y;
        logic [63:0] exp;
        int bc, dc;
        for (int i = 0; i < 30; i++) begin
            o = 3'($urandom_range(0, 3));
            x = ($urandom_range(0, 5) == 0) ? 32'h80000000 : $urandom;
            case ($urandom_range(0, 7))
                0:       y = 32'h0;
                1:       y = 32'hFFFFFFFF;
                2:       y = $urandom_range(1, 15);
                default: y = $urandom;
            endcase
            exp = ref_result(o, x, y);
            run_op(o, x, y, bc, dc);
            checks++; if (bus.hi !== exp[63:32]) begin failures++; $display("FAIL rand%0d_hi op=%0d a=%h b=%h got=%h exp=%h", i, o, x, y, bus.hi, exp[63:32]); end
            checks++; if (bus.lo !== exp[31:0]) begin failures++; $display("FAIL rand%0d_lo op=%0d a=%h b=%h got=%h exp=%h", i, o, x, y, bus.lo, exp[31:0]); end
            checks++; if (bc !== 33 || dc !== 1) begin failures++; $display("FAIL rand%0d_timing got busy=%0d done=%0d exp 33/1", i, bc, dc); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] x1, y1, x2, y2;
        logic [63:0] e1, e2;
        int scnt, bc;
        x1 = $urandom; y1 = $urandom;
        x2 = $urandom; y2 = $urandom_range(1, 50);
        e1 = ref_result(3'b001, x1, y1);
        e2 = ref_result(3'b010, x2, y2);
        bus.start = 1'b1; bus.op = 3'b001; bus.a = x1; bus.b = y1;
        @(posedge clk); #1;
        bus.op = 3'b010; bus.a = x2; bus.b = y2;
        scnt = 0; bc = 0;
        while (bus.busy === 1'b1 && bc < 100) begin
            bc++;
            if (bus.stall === 1'b1) scnt++;
            @(posedge clk); #1;
        end
        checks++; if (scnt !== 33) begin failures++; $display("FAIL b2b_stall_cycles got=%0d exp=33", scnt); end
        checks++; if ({bus.hi, bus.lo} !== e1 || bus.done !== 1'b1) begin failures++; $display("FAIL b2b_first got=%h_%h done=%b exp=%h", bus.hi, bus.lo, bus.done, e1); end
        @(posedge clk); #1;
        bus.start = 1'b0;
        checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL b2b_second_accept got=%b exp=1", bus.busy); end
        bc = 0;
        while (bus.busy === 1'b1 && bc < 100) begin
            bc++;
            @(posedge clk); #1;
        end
        checks++; if (bc !== 33) begin failures++; $display("FAIL b2b_second_busy got=%0d exp=33", bc); end
        checks++; if ({bus.hi, bus.lo} !== e2) begin failures++; $display("FAIL b2b_second_result got=%h_%h exp=%h", bus.hi, bus.lo, e2); end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_multu_max();
        test_directed();
        test_mthi_mtlo();
        test_stall();
        test_flush();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
